// File: rtl/fdiv_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// addpkg_div / fdiv_issue_ctrl_if
//
// addpkg_div      : error codes reported by the Newton-Raphson divider and
//                   echoed on the issue-controller response channel.
// fdiv_issue_ctrl_if : request / response channel between the FPU issue
//                   stage and the divider issue controller.
//   req_valid/req_ready : request handshake (issue stage -> controller)
//   req_a, req_b        : dividend / divisor, IEEE-754 single
//   req_rm              : rounding mode
//   req_tag             : request tag, echoed on the response
//   rsp_valid/rsp_ready : response handshake (controller -> issue stage)
//   rsp_result          : quotient
//   rsp_err             : error code
//   rsp_tag             : echoed tag
//   rsp_timeout         : response produced by timeout rather than the divider
//   modport master      : issue-stage side
//   modport slave       : controller side
// -----------------------------------------------------------------------------
package addpkg_div;

    typedef enum logic [2:0] {
        NONE      = 3'd0,
        INVALID   = 3'd1,
        DIVBYZERO = 3'd2,
        OVERFLOW  = 3'd3,
        UNDERFLOW = 3'd4,
        INEXACT   = 3'd5
    } o_err_t;

endpackage

interface fdiv_issue_ctrl_if #(
    parameter int TAG_W = 4
);
    import addpkg_div::*;

    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [1:0]       req_rm;
    logic [TAG_W-1:0] req_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    o_err_t           rsp_err;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_timeout;

    modport master (
        output req_valid, req_a, req_b, req_rm, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_err, rsp_tag, rsp_timeout
    );

    modport slave (
        input  req_valid, req_a, req_b, req_rm, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_err, rsp_tag, rsp_timeout
    );

endinterface

// File: rtl/fdiv_issue_ctrl.sv
// -----------------------------------------------------------------------------
// fdiv_issue_ctrl
//
// Requester-side controller for the Newton-Raphson FP divider. Accepts one
// divide request at a time, holds the operands on the divider inputs, pulses
// dv_fdiv once, follows dv_busy and the result drain pipe, then returns the
// result on the response channel. A cycle budget forces a quiet-NaN/INVALID
// response if the divider never finishes; flush aborts any operation.
//
// Ports
//   clk, rstn   : clock, asynchronous active-low reset
//   flush       : synchronous abort, returns to IDLE next cycle
//   bus         : request/response channel (slave side)
//   dv_a, dv_b  : operands to the divider, stable from ISSUE to capture
//   dv_rm       : rounding mode to the divider
//   dv_fdiv     : one-cycle start pulse
//   dv_ena      : divider pipeline enable (low in IDLE and RESP)
//   dv_busy     : divider iterating
//   dv_stall    : divider stall request, observed only
//   dv_s, dv_err: divider result and error code
// -----------------------------------------------------------------------------
module fdiv_issue_ctrl
    import addpkg_div::*;
#(
    parameter int TAG_W     = 4,
    parameter int DRAIN_CYC = 3,
    parameter int TIMEOUT   = 64
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                flush,
    fdiv_issue_ctrl_if.slave    bus,
    output logic [31:0]         dv_a,
    output logic [31:0]         dv_b,
    output logic [1:0]          dv_rm,
    output logic                dv_fdiv,
    output logic                dv_ena,
    input  logic                dv_busy,
    input  logic                dv_stall,
    input  logic [31:0]         dv_s,
    input  o_err_t              dv_err
);

    localparam int TMO_W = $clog2(TIMEOUT) + 1;
    localparam int DRN_W = $clog2(DRAIN_CYC) + 1;

    // The tmo counter reads 0 in the first WAIT_BUSY cycle (one cycle after
    // ISSUE). Leaving at TIMEOUT-2 puts RESP exactly TIMEOUT cycles after ISSUE.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 2);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [DRN_W-1:0] DRN_ONE  = DRN_W'(1);
    localparam logic [31:0]      QNAN     = 32'h7fc0_0000;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_ITER      = 3'd3,
        S_DRAIN     = 3'd4,
        S_RESP      = 3'd5
    } state_t;

    state_t           state_r;
    logic             rsp_valid_r;
    logic [31:0]      rsp_result_r;
    o_err_t           rsp_err_r;
    logic [TAG_W-1:0] rsp_tag_r;
    logic             rsp_timeout_r;
    logic [31:0]      dv_a_r;
    logic [31:0]      dv_b_r;
    logic [1:0]       dv_rm_r;
    logic             dv_fdiv_r;
    logic             dv_ena_r;
    logic [TAG_W-1:0] tag_r;
    logic [TMO_W-1:0] tmo_r;
    logic [DRN_W-1:0] drn_r;

    logic counting_s;
    logic tmo_hit_s;
    logic drain_done_s;
    logic unused_stall_s;

    // Sequencing depends on dv_busy only; stall is visible to the divider side.
    assign unused_stall_s = dv_stall;

    assign counting_s   = (state_r == S_WAIT_BUSY) || (state_r == S_ITER) ||
                          (state_r == S_DRAIN);
    assign tmo_hit_s    = counting_s && (tmo_r == TMO_LAST);
    assign drain_done_s = (state_r == S_DRAIN) && (drn_r == DRN_LAST);

    assign bus.req_ready   = (state_r == S_IDLE) && !flush;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_result  = rsp_result_r;
    assign bus.rsp_err     = rsp_err_r;
    assign bus.rsp_tag     = rsp_tag_r;
    assign bus.rsp_timeout = rsp_timeout_r;

    assign dv_a    = dv_a_r;
    assign dv_b    = dv_b_r;
    assign dv_rm   = dv_rm_r;
    assign dv_fdiv = dv_fdiv_r;
    assign dv_ena  = dv_ena_r;

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r       <= S_IDLE;
            rsp_valid_r   <= 1'b0;
            rsp_result_r  <= 32'h0000_0000;
            rsp_err_r     <= NONE;
            rsp_tag_r     <= {TAG_W{1'b0}};
            rsp_timeout_r <= 1'b0;
            dv_a_r        <= 32'h0000_0000;
            dv_b_r        <= 32'h0000_0000;
            dv_rm_r       <= 2'b00;
            dv_fdiv_r     <= 1'b0;
            dv_ena_r      <= 1'b0;
            tag_r         <= {TAG_W{1'b0}};
            tmo_r         <= {TMO_W{1'b0}};
            drn_r         <= {DRN_W{1'b0}};
        end else if (flush) begin
            // Abort: whatever the divider produces later is simply never captured.
            state_r     <= S_IDLE;
            rsp_valid_r <= 1'b0;
            dv_fdiv_r   <= 1'b0;
            dv_ena_r    <= 1'b0;
            tmo_r       <= {TMO_W{1'b0}};
            drn_r       <= {DRN_W{1'b0}};
        end else if (tmo_hit_s && !drain_done_s) begin
            // Divider overran its budget: answer with a default quiet NaN.
            state_r       <= S_RESP;
            rsp_valid_r   <= 1'b1;
            rsp_result_r  <= QNAN;
            rsp_err_r     <= INVALID;
            rsp_tag_r     <= tag_r;
            rsp_timeout_r <= 1'b1;
            dv_ena_r      <= 1'b0;
        end else begin
            if (counting_s) begin
                tmo_r <= tmo_r + TMO_ONE;
            end
            case (state_r)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        dv_a_r    <= bus.req_a;
                        dv_b_r    <= bus.req_b;
                        dv_rm_r   <= bus.req_rm;
                        tag_r     <= bus.req_tag;
                        dv_fdiv_r <= 1'b1;
                        dv_ena_r  <= 1'b1;
                        state_r   <= S_ISSUE;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    dv_fdiv_r <= 1'b0;
                    tmo_r     <= {TMO_W{1'b0}};
                    state_r   <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (dv_busy) begin
                        state_r <= S_ITER;
                    end else begin
                        state_r <= S_WAIT_BUSY;
                    end
                end
                S_ITER: begin
                    if (!dv_busy) begin
                        drn_r   <= {DRN_W{1'b0}};
                        state_r <= S_DRAIN;
                    end else begin
                        state_r <= S_ITER;
                    end
                end
                S_DRAIN: begin
                    if (drain_done_s) begin
                        rsp_valid_r   <= 1'b1;
                        rsp_result_r  <= dv_s;
                        rsp_err_r     <= dv_err;
                        rsp_tag_r     <= tag_r;
                        rsp_timeout_r <= 1'b0;
                        dv_ena_r      <= 1'b0;
                        state_r       <= S_RESP;
                    end else begin
                        drn_r <= drn_r + DRN_ONE;
                    end
                end
                S_RESP: begin
                    // Return to IDLE only; a new request waits for the next cycle.
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= S_IDLE;
                    end else begin
                        state_r <= S_RESP;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    rsp_valid_r <= 1'b0;
                    dv_fdiv_r   <= 1'b0;
                    dv_ena_r    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fdiv_issue_ctrl
//
// Directed bench for fdiv_issue_ctrl. A small divider model raises dv_busy
// for a programmed number of cycles after dv_fdiv and presents the result
// only in the single cycle the controller must capture it. Expected
// responses are queued when a request is issued; a monitor pops and
// compares on every response handshake.
// -----------------------------------------------------------------------------
module tb_fdiv_issue_ctrl;
    import addpkg_div::*;

    localparam int TAG_W     = 4;
    localparam int DRAIN_CYC = 3;
    localparam int TIMEOUT   = 16;

    typedef struct {
        logic [31:0]      res;
        o_err_t           err;
        logic [TAG_W-1:0] tag;
        logic             tmo;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] dv_a, dv_b, dv_s;
    logic [1:0]  dv_rm;
    logic        dv_fdiv, dv_ena, dv_busy, dv_stall;
    o_err_t      dv_err;

    fdiv_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

    fdiv_issue_ctrl #(
        .TAG_W(TAG_W), .DRAIN_CYC(DRAIN_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .bus(bus),
        .dv_a(dv_a), .dv_b(dv_b), .dv_rm(dv_rm), .dv_fdiv(dv_fdiv), .dv_ena(dv_ena),
        .dv_busy(dv_busy), .dv_stall(dv_stall), .dv_s(dv_s), .dv_err(dv_err)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          t0 = 0;
    int          fdiv_cnt = 0;
    int          mdl_len = 0;
    logic        armed = 1'b0;
    logic [31:0] mdl_res = 32'h0;
    o_err_t      mdl_err = NONE;
    logic [31:0] seen_a = 32'h0;
    logic [31:0] seen_b = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Divider model: busy for mdl_len cycles starting the cycle after dv_fdiv,
    // result valid only DRAIN_CYC cycles after the first busy-low cycle.
    initial begin
        dv_busy  = 1'b0;
        dv_stall = 1'b0;
        dv_s     = 32'hDEAD_BEEF;
        dv_err   = OVERFLOW;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (dv_fdiv) begin
                t0     = cyc;
                armed  = 1'b1;
                fdiv_cnt++;
                seen_a = dv_a;
                seen_b = dv_b;
            end
            dv_busy  = armed && (mdl_len > 0) && (cyc - t0 >= 1) && (cyc - t0 <= mdl_len);
            dv_stall = dv_busy;
            if (armed && (mdl_len > 0) && (cyc - t0 == mdl_len + DRAIN_CYC + 1)) begin
                dv_s   = mdl_res;
                dv_err = mdl_err;
            end else begin
                dv_s   = 32'hDEAD_BEEF;
                dv_err = OVERFLOW;
            end
        end
    end

    // Response monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got tag %0d, expected no response", bus.rsp_tag);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_result", bus.rsp_result, e.res);
                    chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                    chk("rsp_tag", 32'(bus.rsp_tag), 32'(e.tag));
                    chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.tmo));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_vals(input string tg);
        chk({tg, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tg, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tg, "_rsp_result"}, bus.rsp_result, 32'd0);
        chk({tg, "_rsp_err"}, 32'(bus.rsp_err), 32'(NONE));
        chk({tg, "_rsp_tag"}, 32'(bus.rsp_tag), 32'd0);
        chk({tg, "_rsp_timeout"}, 32'(bus.rsp_timeout), 32'd0);
        chk({tg, "_dv_a"}, dv_a, 32'd0);
        chk({tg, "_dv_b"}, dv_b, 32'd0);
        chk({tg, "_dv_rm"}, 32'(dv_rm), 32'd0);
        chk({tg, "_dv_fdiv"}, 32'(dv_fdiv), 32'd0);
        chk({tg, "_dv_ena"}, 32'(dv_ena), 32'd0);
    endtask

    // Drive one request; returns in the ISSUE cycle (just after the accept edge).
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                         input logic [TAG_W-1:0] tag, input logic [31:0] res,
                         input o_err_t err, input logic tmo, input bit expect_rsp);
        int g;
        @(posedge clk);
        #1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_rm    = rm;
        bus.req_tag   = tag;
        bus.req_valid = 1'b1;
        g = 0;
        @(negedge clk);
        while (!bus.req_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) begin
            chk("req_accept_bound", 32'(bus.req_ready), 32'd1);
        end
        if (expect_rsp) begin
            exp_q.push_back('{res: res, err: err, tag: tag, tmo: tmo});
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Wait for the response to appear; returns its latency from ISSUE.
    task automatic wait_rsp_valid(input string tg, output int lat);
        int g;
        g = 0;
        @(negedge clk);
        while (!bus.rsp_valid && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) begin
            chk({tg, "_rsp_bound"}, 32'(bus.rsp_valid), 32'd1);
        end
        lat = cyc - t0;
    endtask

    task automatic wait_drained(input string tg);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk({tg, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int  lat;
        int  f0;
        bit  seen_rv;
        bus.req_valid = 1'b0;
        bus.req_a     = 32'h0;
        bus.req_b     = 32'h0;
        bus.req_rm    = 2'b00;
        bus.req_tag   = 4'h0;
        bus.rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        check_reset_vals("rst_low");
        rstn = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_rel");

        // 1: 6.0 / 2.0 = 3.0
        mdl_len = 6; mdl_res = 32'h4040_0000; mdl_err = NONE;
        f0 = fdiv_cnt;
        issue(32'h40C0_0000, 32'h4000_0000, 2'd0, 4'd5, 32'h4040_0000, NONE, 1'b0, 1'b1);
        wait_rsp_valid("t1", lat);
        chk("t1_latency", 32'(lat), 32'(mdl_len + DRAIN_CYC + 2));
        wait_drained("t1");
        chk("t1_fdiv_pulses", 32'(fdiv_cnt - f0), 32'd1);
        chk("t1_dv_a", seen_a, 32'h40C0_0000);
        chk("t1_dv_b", seen_b, 32'h4000_0000);

        // 2: 1.0 / 0.0
        mdl_len = 4; mdl_res = 32'h7F80_0000; mdl_err = DIVBYZERO;
        issue(32'h3F80_0000, 32'h0000_0000, 2'd0, 4'd2, 32'h7F80_0000, DIVBYZERO, 1'b0, 1'b1);
        wait_drained("t2");
        chk("t2_dv_b", seen_b, 32'h0000_0000);

        // 3: response back-pressure
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        mdl_len = 6; mdl_res = 32'h4040_0000; mdl_err = NONE;
        issue(32'h40C0_0000, 32'h4000_0000, 2'd0, 4'd5, 32'h4040_0000, NONE, 1'b0, 1'b1);
        wait_rsp_valid("t3", lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_rsp_valid_hold", 32'(bus.rsp_valid), 32'd1);
            chk("t3_rsp_result_hold", bus.rsp_result, 32'h4040_0000);
            chk("t3_rsp_tag_hold", 32'(bus.rsp_tag), 32'd5);
            chk("t3_req_ready_low", 32'(bus.req_ready), 32'd0);
            chk("t3_dv_ena_low", 32'(dv_ena), 32'd0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t3_idle_req_ready", 32'(bus.req_ready), 32'd1);
        chk("t3_idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        wait_drained("t3");

        // 4: divider never goes busy -> timeout
        mdl_len = 0;
        issue(32'h4000_0000, 32'h4000_0000, 2'd1, 4'd9, 32'h7FC0_0000, INVALID, 1'b1, 1'b1);
        wait_rsp_valid("t4", lat);
        chk("t4_tmo_latency", 32'(lat), 32'(TIMEOUT));
        wait_drained("t4");

        // 5: flush during ITER with a competing request
        mdl_len = 8; mdl_res = 32'h4000_0000; mdl_err = NONE;
        issue(32'h4080_0000, 32'h4000_0000, 2'd0, 4'd3, 32'h0, NONE, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("t5_in_iter_ena", 32'(dv_ena), 32'd1);
        flush         = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_tag   = 4'd12;
        @(negedge clk);
        chk("t5_req_ready_flush", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        flush         = 1'b0;
        bus.req_valid = 1'b0;
        f0 = fdiv_cnt;
        @(negedge clk);
        chk("t5_idle_req_ready", 32'(bus.req_ready), 32'd1);
        chk("t5_dv_ena", 32'(dv_ena), 32'd0);
        chk("t5_dv_fdiv", 32'(dv_fdiv), 32'd0);
        seen_rv = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen_rv = 1'b1;
        end
        chk("t5_no_rsp", 32'(seen_rv), 32'd0);
        chk("t5_not_accepted", 32'(fdiv_cnt - f0), 32'd0);
        mdl_len = 5; mdl_res = 32'h3F00_0000; mdl_err = NONE;
        issue(32'h3F80_0000, 32'h4000_0000, 2'd0, 4'd6, 32'h3F00_0000, NONE, 1'b0, 1'b1);
        wait_drained("t5");

        // 6: asynchronous reset during DRAIN
        mdl_len = 3; mdl_res = 32'h4100_0000; mdl_err = NONE;
        issue(32'h4180_0000, 32'h4000_0000, 2'd2, 4'd4, 32'h0, NONE, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        chk("t6_in_drain_ena", 32'(dv_ena), 32'd1);
        #1;
        rstn = 1'b0;
        #1;
        check_reset_vals("t6_async");
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        seen_rv = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen_rv = 1'b1;
        end
        chk("t6_no_rsp", 32'(seen_rv), 32'd0);

        // Recovery after reset
        mdl_len = 2; mdl_res = 32'h4040_0000; mdl_err = INEXACT;
        issue(32'h4040_0000, 32'h3F80_0000, 2'd3, 4'd1, 32'h4040_0000, INEXACT, 1'b0, 1'b1);
        wait_drained("t7");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
